// File: rtl/gf_mul_digit_serial_if.sv
// Operand/result handshake bundle for the digit-serial GF(2^WIDTH) multiplier.
interface gf_mul_digit_serial_if #(
  parameter int unsigned WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, mode, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, mode, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/gf_mul_digit_serial.sv
// Digit-serial GF(2^WIDTH) multiplier, MSB-first Horner over b, DIGIT bits per
// cycle. Constant latency of WIDTH/DIGIT + 1 cycles; optional GCM bit order.
module gf_mul_digit_serial #(
  parameter int unsigned      WIDTH = 128,
  parameter int unsigned      DIGIT = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(128'h87)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gf_mul_digit_serial_if.slave bus
);

  localparam int unsigned     STEPS    = WIDTH / DIGIT;
  localparam int unsigned     CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [DIGIT-1:0] digit_c;
  logic [WIDTH-1:0] step_c;

  // Multiply by x modulo P; the x^WIDTH carry folds back as POLY.
  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
  endfunction

  // Bit reversal converts between GCM order and polynomial order.
  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  assign digit_c = b_q[WIDTH-1 -: DIGIT];

  // One Horner step: acc*x^DIGIT + a*digit, reduced one bit at a time.
  always_comb begin
    step_c = acc_q;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      step_c = xtime(step_c) ^ (digit_c[i] ? a_q : '0);
    end
  end

  // Next-state, datapath update and registered output decode.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = BUSY;
          a_d     = bus.mode ? bitrev(bus.a) : bus.a;
          b_d     = bus.mode ? bitrev(bus.b) : bus.b;
          mode_d  = bus.mode;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        acc_d = step_c;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = mode_q ? bitrev(step_c) : step_c;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition, including an accept in IDLE.
    if (bus.flush) begin
      state_d = IDLE;
      acc_d   = '0;
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;

endmodule
